// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-outstanding memory request/response bus
interface mem_port_arbiter_if #(
   parameter int N  = 32,
   parameter int AW = 32
);
   logic          proc_req;
   logic          we;
   logic [AW-1:0] addr;
   logic [N-1:0]  wdata;
   logic          mem_rdy;
   logic          valid;
   logic [N-1:0]  rdata;

   modport master (
      output proc_req, we, addr, wdata,
      input  mem_rdy, valid, rdata
   );

   modport slave (
      input  proc_req, we, addr, wdata,
      output mem_rdy, valid, rdata
   );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - winner selection; ARB_RR_EN selects round-robin over fixed D>IF
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
`ifdef ARB_RR_EN
   input  owner_t last_grant,
`endif
   output owner_t grant
);

   always_comb begin
      grant = OWN_IF;
`ifdef ARB_RR_EN
      if (if_req && d_req) begin
         grant = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
      end else if (d_req) begin
         grant = OWN_D;
      end
`else
      if (d_req) begin
         grant = OWN_D;
      end else if (if_req) begin
         grant = OWN_IF;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/D arbiter and sequencer for the shared memory port
// ARB_RR_EN: define for round-robin arbitration, leave undefined for fixed D-over-IF priority
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_valid,
   output logic [N-1:0]  if_rdata,
   output logic          if_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [N-1:0]  d_wdata,
   output logic          d_valid,
   output logic [N-1:0]  d_rdata,
   output logic          d_stall,
   mem_port_arbiter_if.master mem,
   output logic          busy
);

   state_t        state;
   owner_t        owner;
   owner_t        grant;
   logic          proc_req_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [N-1:0]  wdata_q;
   logic          resp;

`ifdef ARB_RR_EN
   owner_t        last_grant;
`endif

   arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
`ifdef ARB_RR_EN
      .last_grant (last_grant),
`endif
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IF;
         proc_req_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef ARB_RR_EN
         last_grant <= OWN_IF;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (if_req || d_req) begin
                  state      <= ST_REQ;
                  owner      <= grant;
                  proc_req_q <= 1'b1;
`ifdef ARB_RR_EN
                  last_grant <= grant;
`endif
                  // Fetches never write, so their write fields are forced to zero.
                  if (grant == OWN_D) begin
                     addr_q  <= d_addr;
                     we_q    <= d_we;
                     wdata_q <= d_wdata;
                  end else begin
                     addr_q  <= if_addr;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (mem.mem_rdy) begin
                  state      <= ST_WAIT;
                  proc_req_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (mem.valid) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state      <= ST_IDLE;
               proc_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem.proc_req = proc_req_q;
   assign mem.we       = we_q;
   assign mem.addr     = addr_q;
   assign mem.wdata    = wdata_q;

   // A response only counts in WAIT; strobes in IDLE/REQ are stale or illegal.
   assign resp     = (state == ST_WAIT) && mem.valid;
   assign if_valid = resp && (owner == OWN_IF);
   assign d_valid  = resp && (owner == OWN_D);
   assign if_rdata = if_valid ? mem.rdata : '0;
   assign d_rdata  = d_valid ? mem.rdata : '0;
   assign if_stall = if_req && !if_valid;
   assign d_stall  = d_req && !d_valid;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench against a transaction-level arbiter model
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        busy;

   int checks;
   int failures;
   bit model_last;   // 1 = D was granted last
   bit pend_if;
   bit pend_d;

   mem_port_arbiter_if #(.N(32), .AW(32)) mem_bus ();

   mem_port_arbiter #(.N(32), .AW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_valid (if_valid),
      .if_rdata (if_rdata),
      .if_stall (if_stall),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_valid  (d_valid),
      .d_rdata  (d_rdata),
      .d_stall  (d_stall),
      .mem      (mem_bus.master),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic check_resp(input string tag, input bit eiv, input bit edv, input logic [31:0] erd);
      check_eq({tag, "_if_valid"}, if_valid, eiv);
      check_eq({tag, "_d_valid"}, d_valid, edv);
      check_eq({tag, "_if_rdata"}, if_rdata, eiv ? erd : 32'h0);
      check_eq({tag, "_d_rdata"}, d_rdata, edv ? erd : 32'h0);
      check_eq({tag, "_if_stall"}, if_stall, if_req & ~eiv);
      check_eq({tag, "_d_stall"}, d_stall, d_req & ~edv);
   endtask

   function automatic bit model_pick(input bit pi, input bit pd);
      if (pi && pd) begin
`ifdef ARB_RR_EN
         return !model_last;
`else
         return 1'b1;
`endif
      end
      return pd;
   endfunction

   // One granted transaction, starting in the IDLE cycle in which the winner is chosen.
   task automatic serve(input bit is_d, input int rdy_d, input int v_d,
                        input logic [31:0] rd, input bit drop);
      logic [31:0] e_addr;
      logic        e_we;
      logic [31:0] e_wd;
      e_addr = is_d ? d_addr : if_addr;
      e_we   = is_d ? d_we : 1'b0;
      e_wd   = is_d ? d_wdata : 32'h0;

      settle();
      check_eq("arb_busy", busy, 1'b0);
      check_eq("arb_proc_req", mem_bus.proc_req, 1'b0);
      check_resp("arb", 1'b0, 1'b0, 32'h0);
      tick();

      for (int i = 0; i <= rdy_d; i++) begin
         mem_bus.mem_rdy = (i == rdy_d);
         mem_bus.valid   = (i == rdy_d) ? 1'b0 : 1'($urandom);
         mem_bus.rdata   = $urandom;
         settle();
         check_eq("req_proc_req", mem_bus.proc_req, 1'b1);
         check_eq("req_addr", mem_bus.addr, e_addr);
         check_eq("req_we", mem_bus.we, e_we);
         check_eq("req_wdata", mem_bus.wdata, e_wd);
         check_eq("req_busy", busy, 1'b1);
         check_resp("req", 1'b0, 1'b0, 32'h0);
         tick();
      end

      mem_bus.valid = 1'b0;
      for (int i = 0; i < v_d; i++) begin
         mem_bus.mem_rdy = 1'($urandom);
         if (drop && i == 0) begin
            if (is_d) d_req = 1'b0; else if_req = 1'b0;
         end
         settle();
         check_eq("wait_proc_req", mem_bus.proc_req, 1'b0);
         check_eq("wait_busy", busy, 1'b1);
         check_resp("wait", 1'b0, 1'b0, 32'h0);
         tick();
      end

      if (drop) begin
         if (is_d) d_req = 1'b0; else if_req = 1'b0;
      end
      mem_bus.valid = 1'b1;
      mem_bus.rdata = rd;
      settle();
      check_eq("resp_proc_req", mem_bus.proc_req, 1'b0);
      check_eq("resp_addr_hold", mem_bus.addr, e_addr);
      check_resp("resp", !is_d, is_d, rd);
      tick();

      mem_bus.valid   = 1'b0;
      mem_bus.mem_rdy = 1'b0;
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
   endtask

   initial begin
      bit w;
      checks     = 0;
      failures   = 0;
      model_last = 1'b0;
      pend_if    = 1'b0;
      pend_d     = 1'b0;
      rst     = 1'b0;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      mem_bus.mem_rdy = 1'b0;
      mem_bus.valid   = 1'b0;
      mem_bus.rdata   = '0;
      tick();
      tick();
      settle();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_proc_req", mem_bus.proc_req, 1'b0);
      check_eq("rst_we", mem_bus.we, 1'b0);
      check_eq("rst_addr", mem_bus.addr, 32'h0);
      check_eq("rst_wdata", mem_bus.wdata, 32'h0);
      check_resp("rst", 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b1;

      // Single fetch: ready at once, response in cycle 3.
      if_addr = 32'h100;
      if_req  = 1'b1;
      model_last = 1'b0;
      serve(1'b0, 0, 1, 32'hDEADBEEF, 1'b0);

      // Store with memory not ready for three cycles.
      d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_req = 1'b1;
      model_last = 1'b1;
      serve(1'b1, 3, 0, 32'h0BADF00D, 1'b0);

      // Simultaneous requests.
      if_addr = 32'h300; if_req = 1'b1;
      d_we = 1'b0; d_addr = 32'h4000; d_req = 1'b1;
      w = model_pick(1'b1, 1'b1);
      model_last = w;
      serve(w, 0, 0, 32'hA5A5A5A5, 1'b0);
      w = !w;
      model_last = w;
      serve(w, 1, 0, 32'h5A5A5A5A, 1'b0);

      // Reset while a load waits for its response; the late response is dropped.
      d_we = 1'b0; d_addr = 32'h5000; d_req = 1'b1;
      tick();
      mem_bus.mem_rdy = 1'b1;
      tick();
      mem_bus.mem_rdy = 1'b0;
      rst   = 1'b0;
      d_req = 1'b0;
      tick();
      rst = 1'b1;
      mem_bus.valid = 1'b1;
      mem_bus.rdata = 32'hFFFF0000;
      settle();
      check_eq("rstw_busy", busy, 1'b0);
      check_eq("rstw_proc_req", mem_bus.proc_req, 1'b0);
      check_eq("rstw_addr", mem_bus.addr, 32'h0);
      check_eq("rstw_we", mem_bus.we, 1'b0);
      check_eq("rstw_wdata", mem_bus.wdata, 32'h0);
      check_resp("rstw", 1'b0, 1'b0, 32'h0);
      tick();
      mem_bus.valid = 1'b0;
      settle();
      check_eq("rstw_no_grant", busy, 1'b0);
      check_eq("rstw_no_req", mem_bus.proc_req, 1'b0);
      tick();
      model_last = 1'b0;

      // Randomized traffic with occasional idle cycles and stray valids.
      for (int it = 0; it < 300; it++) begin
         if (!pend_if && ($urandom % 2 == 0)) begin
            pend_if = 1'b1;
            if_addr = $urandom;
         end
         if (!pend_d && ($urandom % 2 == 0)) begin
            pend_d  = 1'b1;
            d_addr  = $urandom;
            d_we    = 1'($urandom);
            d_wdata = $urandom;
         end
         if_req = pend_if;
         d_req  = pend_d;
         if (!pend_if && !pend_d) begin
            mem_bus.valid = 1'($urandom);
            mem_bus.rdata = $urandom;
            settle();
            check_eq("idle_busy", busy, 1'b0);
            check_eq("idle_proc_req", mem_bus.proc_req, 1'b0);
            check_resp("idle", 1'b0, 1'b0, 32'h0);
            tick();
            mem_bus.valid = 1'b0;
         end else begin
            w = model_pick(pend_if, pend_d);
            model_last = w;
            serve(w, int'($urandom % 4), int'($urandom % 4), $urandom, ($urandom % 4) == 0);
            if (w) pend_d = 1'b0; else pend_if = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the core's single shared memory port. It serves two requesters: instruction fetch (IF) and the MEM-stage load/store unit (D). It selects one owner, drives the memory handshake (proc_req/we/addr/wdata, mem_rdy, valid/rdata) for exactly one outstanding transaction, and routes the response back to the owner. It sits between the IF stage, the MEM stage and the external memory model, and it produces the per-requester stall signals the pipeline control uses to freeze stages.

## Interface
Parameters:
- N, 32, data width (wdata/rdata)
- AW, 32, address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (state reset on a rising edge of clk while rst=0)
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  AW  fetch address; stable while if_req=1
- if_valid  out  1  fetch response strobe, one cycle
- if_rdata  out  N  fetch data, meaningful when if_valid=1
- if_stall  out  1  if_req & ~if_valid
- d_req  in  1  load/store request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  N  store data
- d_valid  out  1  load data / store-complete strobe, one cycle
- d_rdata  out  N  load data
- d_stall  out  1  d_req & ~d_valid
- proc_req  out  1  memory request
- we  out  1  memory write enable
- addr  out  AW  memory address
- wdata  out  N  memory write data
- mem_rdy  in  1  memory accepts request when proc_req & mem_rdy
- valid  in  1  memory response strobe
- rdata  in  N  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: if either request is asserted, pick the winner, latch its addr/we/wdata into the output registers, set owner, and go to REQ. With no request, stay in IDLE.
- Fetch requests latch we=0 and wdata=0.
- REQ: proc_req=1. On mem_rdy=1, go to WAIT; otherwise stay in REQ with latched outputs unchanged.
- WAIT: proc_req=0. On valid=1, pulse the owner's x_valid in that same cycle and pass rdata combinationally to x_rdata, then go to IDLE. The non-owner's valid stays 0.
- valid is ignored outside WAIT. A valid in the acceptance cycle itself is not legal from the memory model.
- If a requester drops req mid-transaction, the transaction still completes. x_valid is still pulsed and the requester ignores it.
- Outputs addr/we/wdata hold their last value outside REQ. proc_req is 0 outside REQ.
- if_rdata and d_rdata are 0 when their valid is 0.
- Fixed priority (macro off): D wins over IF.
- Reset: all state returns to IDLE, owner=IF, last_grant=IF, and every output becomes 0. A reset during REQ or WAIT abandons the transaction, and any later valid from it is discarded because it arrives while the FSM is in IDLE.

## Timing
- x_req rises in cycle 0 with the FSM in IDLE. The FSM is in REQ in cycle 1, with proc_req=1 and addr=x_addr.
- If mem_rdy=1 in cycle 1, the FSM is in WAIT in cycle 2.
- valid in cycle k≥2 gives x_valid=1 in cycle k, and IDLE in cycle k+1.
- Minimum transaction: 3 cycles from request to response. Back-to-back transactions add one IDLE cycle; the next proc_req is in cycle k+2.
- Stalls are combinational: x_stall=1 from the first cycle of x_req through the cycle before x_valid, and 0 in the x_valid cycle.

## Configuration
- ARB_RR_EN defined: round-robin. When both requests are present in IDLE, grant the requester that is not last_grant. last_grant updates on every IDLE→REQ transition. A single requester is always granted.
- ARB_RR_EN undefined: fixed priority, D over IF. The last_grant register is not synthesized.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/REQ/WAIT)
  - the owner enum (OWN_IF/OWN_D)
- Sub-module arb_pick: combinational winner selection from (if_req, d_req, last_grant), containing the ARB_RR_EN logic.
- FSM, latched request registers and response routing live in the top module.

## Test plan
- Single fetch, if_addr=0x100, mem_rdy=1, valid in cycle 3 with rdata=0xDEADBEEF. Required: proc_req in cycle 1, if_valid and if_rdata=0xDEADBEEF in cycle 3, if_stall=1 in cycles 0–2.
- Store, d_we=1, d_addr=0x2000, d_wdata=0x12345678, mem_rdy low for 3 cycles. Required: proc_req stays 1 with stable we/addr/wdata for 4 cycles, then d_valid on valid.
- Both requests in cycle 0, macro off. Required: D granted first (addr=d_addr); IF granted in the IDLE after d_valid.
- Both requests held continuously with ARB_RR_EN defined. Required: grants alternate D, IF, D, IF after reset (last_grant=IF); no requester is granted twice in a row.
- Load in WAIT with rst=0 for one cycle, then valid=1 arrives. Required: FSM in IDLE, d_valid=0, all outputs 0, no spurious grant.
- valid asserted while in IDLE or REQ. Required: no x_valid pulse and no state change.
